axi_interconnect_width_convert_rdata: RTL

Read-data merger of the AXI4 width converter: accepts narrow read-data beats from the downstream (master-side) R channel and packs them into wide read beats on the upstream (slave-side) R channel. It consumes the per-burst split descriptors (`split_*`) produced by the request-address splitter. Together with that splitter it forms the wide-to-narrow read path of the interconnect.

---
 rtl/axi_interconnect_pkg.sv | 39 +++
 rtl/axi_interconnect_sync_fifo.sv | 67 ++++++
 rtl/axi_interconnect_width_convert_rdata.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi_interconnect_pkg.sv
// Shared definitions for the AXI interconnect width-converter read path:
// RRESP codes, split-descriptor layout and small elaboration helpers.
package axi_interconnect_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_e;

  localparam int unsigned SPLIT_LEN_W  = 8;
  localparam int unsigned SPLIT_OFF_W  = 8;
  localparam int unsigned SPLIT_SIZE_W = 3;

  typedef struct packed {
    logic [SPLIT_LEN_W-1:0]  len;
    logic [SPLIT_OFF_W-1:0]  offset;
    logic [SPLIT_SIZE_W-1:0] size;
    logic                    tlast;
  } split_desc_t;

  localparam int unsigned SPLIT_DESC_W = $bits(split_desc_t);

  // Codes are ordered by severity, so the worst response is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned CLOG2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_interconnect_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count.
// A push while full is accepted when a pop happens in the same cycle.
module axi_interconnect_sync_fifo
  import axi_interconnect_pkg::*;
#(
  parameter  int unsigned WIDTH = 20,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = CLOG2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? CLOG2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CW-1:0]    w_count_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop_ok    = i_pop && !r_empty;
  assign w_push_ok   = i_push && (!r_full || w_pop_ok);
  assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/axi_interconnect_width_convert_rdata.sv
// Read-data merger: packs narrow R beats into wide R beats according to the
// split descriptors queued by the address splitter.
module axi_interconnect_width_convert_rdata
  import axi_interconnect_pkg::*;
#(
  parameter  int unsigned WIDTH_ID    = 4,
  parameter  int unsigned WIDTH_SDATA = 64,
  parameter  int unsigned WIDTH_MDATA = 32,
  parameter  int unsigned WIDTH_RUSER = 1,
  parameter  int unsigned CMD_DEPTH   = 4,
  parameter  int unsigned U_DLY       = 1,
  localparam int unsigned W_ID        = (WIDTH_ID == 0) ? 1 : WIDTH_ID,
  localparam int unsigned W_RUSER     = (WIDTH_RUSER == 0) ? 1 : WIDTH_RUSER
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   split_en,
  input  logic [7:0]             split_len,
  input  logic [7:0]             split_offset,
  input  logic [2:0]             split_size,
  input  logic                   split_tlast,
  output logic                   cmd_full,
  output logic                   err_ovf,
  output logic                   err_len,
  input  logic [W_ID-1:0]        m_rid,
  input  logic [WIDTH_MDATA-1:0] m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  input  logic [W_RUSER-1:0]     m_ruser,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  output logic [W_ID-1:0]        s_rid,
  output logic [WIDTH_SDATA-1:0] s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic [W_RUSER-1:0]     s_ruser,
  output logic                   s_rvalid,
  input  logic                   s_rready
);

  localparam int unsigned R   = WIDTH_SDATA / WIDTH_MDATA;
  localparam int unsigned LP  = CLOG2(R);
  localparam int unsigned LPW = (LP == 0) ? 1 : LP;
  localparam int unsigned MB  = CLOG2(WIDTH_MDATA / 8);
  localparam int unsigned CCW = CLOG2(CMD_DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  // Register updates are zero-delay; the delay parameter is kept for drop-in use.
  logic w_unused_dly;
  assign w_unused_dly = (U_DLY != 0);

  state_e           r_state;
  state_e           w_state_nxt;
  split_desc_t      w_push_desc;
  split_desc_t      w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CCW-1:0]   w_fifo_count;

  logic                   r_fresh;
  logic [LPW-1:0]         r_ptr;
  logic [8:0]             r_cnt;
  logic [1:0]             r_resp;
  logic [WIDTH_SDATA-1:0] r_acc;

  logic [W_ID-1:0]        r_s_rid;
  logic [WIDTH_SDATA-1:0] r_s_rdata;
  logic [1:0]             r_s_rresp;
  logic                   r_s_rlast;
  logic [W_RUSER-1:0]     r_s_ruser;
  logic                   r_s_rvalid;
  logic                   r_err_ovf;
  logic                   r_err_len;

  logic                   w_hs;
  logic                   w_pop;
  logic                   w_push_ok;
  logic [2:0]             w_size_k;
  logic [LPW-1:0]         w_mask;
  logic [LPW-1:0]         w_off_lane;
  logic [LPW-1:0]         w_ptr;
  logic [LPW-1:0]         w_ptr_inc;
  logic                   w_close;
  logic [1:0]             w_resp_nxt;
  logic [WIDTH_SDATA-1:0] w_acc_nxt;

  assign w_push_desc = '{len: split_len, offset: split_offset, size: split_size, tlast: split_tlast};

  axi_interconnect_sync_fifo #(
    .WIDTH (SPLIT_DESC_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk_sys),
    .rst     (rst),
    .i_push  (split_en),
    .i_pop   (w_pop),
    .i_data  (w_push_desc),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign m_rready  = (r_state == ST_ACTIVE) && !w_fifo_empty && (!r_s_rvalid || s_rready);
  assign w_hs      = m_rvalid && m_rready;
  assign w_pop     = w_hs && m_rlast;
  assign w_push_ok = split_en && (!w_fifo_full || w_pop);

  // r_fresh marks the first beat of a descriptor: the pointer then comes from
  // the head offset, so a freshly queued descriptor needs no extra load cycle.
  assign w_size_k   = (32'(w_head.size) > LP) ? 3'(LP) : w_head.size;
  assign w_mask     = LPW'((32'd1 << w_size_k) - 32'd1);
  assign w_off_lane = LPW'((32'(w_head.offset) >> MB) & (R - 1));
  assign w_ptr      = r_fresh ? w_off_lane : r_ptr;
  assign w_ptr_inc  = LPW'((32'(w_ptr) + 32'd1) & (R - 1));
  assign w_close    = ((w_ptr_inc & w_mask) == '0) || m_rlast;
  assign w_resp_nxt = resp_max(r_resp, m_rresp);

  always_comb begin
    w_acc_nxt = r_acc;
    if (w_size_k == 3'd0) w_acc_nxt = {R{m_rdata}};
    else                  w_acc_nxt[w_ptr*WIDTH_MDATA +: WIDTH_MDATA] = m_rdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_push_ok) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_pop && !w_push_ok && (w_fifo_count == CCW'(1))) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fresh    <= 1'b1;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_resp     <= RESP_OKAY;
      r_acc      <= '0;
      r_s_rid    <= '0;
      r_s_rdata  <= '0;
      r_s_rresp  <= '0;
      r_s_rlast  <= 1'b0;
      r_s_ruser  <= '0;
      r_s_rvalid <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_err_len  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (split_en && w_fifo_full && !w_pop) r_err_ovf <= 1'b1;
      if (r_s_rvalid && s_rready) r_s_rvalid <= 1'b0;
      if (w_hs) begin
        r_fresh <= m_rlast;
        r_ptr   <= w_ptr_inc;
        if (m_rlast) begin
          r_cnt <= '0;
          if (r_cnt != {1'b0, w_head.len}) r_err_len <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 9'd1;
        end
        if (w_close) begin
          r_s_rid    <= m_rid;
          r_s_rdata  <= w_acc_nxt;
          r_s_rresp  <= w_resp_nxt;
          r_s_rlast  <= m_rlast && w_head.tlast;
          r_s_ruser  <= m_ruser;
          r_s_rvalid <= 1'b1;
          r_acc      <= '0;
          r_resp     <= RESP_OKAY;
        end else begin
          r_acc  <= w_acc_nxt;
          r_resp <= w_resp_nxt;
        end
      end
    end
  end

  assign s_rid    = r_s_rid;
  assign s_rdata  = r_s_rdata;
  assign s_rresp  = r_s_rresp;
  assign s_rlast  = r_s_rlast;
  assign s_ruser  = r_s_ruser;
  assign s_rvalid = r_s_rvalid;
  assign cmd_full = w_fifo_full;
  assign err_ovf  = r_err_ovf;
  assign err_len  = r_err_len;

endmodule
